// File: rtl/coo_to_adj.sv
// COO edge-list to dense adjacency bit-matrix builder.
// Accepts one (row, col) edge per handshake and optionally closes the matrix with A+I.
module coo_to_adj #(
    parameter int num_of_nodes = 6,
    parameter int idx_w        = 3,
    parameter bit symmetric    = 1'b1,
    parameter bit self_loops   = 1'b1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic                                         edge_valid,
    output logic                                         edge_ready,
    input  logic [idx_w-1:0]                             edge_row,
    input  logic [idx_w-1:0]                             edge_col,
    input  logic                                         edge_last,
    output logic [num_of_nodes-1:0][num_of_nodes-1:0]    adj_mat,
    output logic                                         coo_adj_done,
    output logic [7:0]                                   edge_count,
    output logic                                         idx_err
);

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;

    localparam logic [idx_w:0] NODES = (idx_w + 1)'(num_of_nodes);

    state_t state, state_nxt;
    logic   hs;
    logic   go;
    logic   in_range;
    logic [num_of_nodes-1:0][num_of_nodes-1:0] adj_nxt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = LOAD;
            LOAD:    if (hs && edge_last) state_nxt = DONE;
            DONE:    if (start) state_nxt = CLEAR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        edge_ready   = (state == LOAD);
        coo_adj_done = (state == DONE);
    end

    assign hs       = edge_valid & edge_ready;
    // Clearing on entry to CLEAR makes the old matrix vanish together with coo_adj_done.
    assign go       = start & ((state == IDLE) | (state == DONE));
    assign in_range = ({1'b0, edge_row} < NODES) && ({1'b0, edge_col} < NODES);

    always_comb begin
        adj_nxt = adj_mat;
        if (in_range) begin
            adj_nxt[edge_row][edge_col] = 1'b1;
            if (symmetric) adj_nxt[edge_col][edge_row] = 1'b1;
        end
        // Diagonal lands on the same edge as the final beat.
        if (edge_last && self_loops) begin
            for (int i = 0; i < num_of_nodes; i++) adj_nxt[i][i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || go) begin
            adj_mat    <= '0;
            edge_count <= '0;
            idx_err    <= 1'b0;
        end else if (hs) begin
            adj_mat    <= adj_nxt;
            edge_count <= sat_inc(edge_count);
            if (!in_range) idx_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_coo_to_adj.sv
// Bench for coo_to_adj: two instances (A+I symmetric, and plain directed) fed the same beats,
// each compared against an edge-list reference model.
module tb_coo_to_adj;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, edge_valid, edge_last;
    logic [2:0] edge_row, edge_col;

    logic            edge_ready_a, done_a, idx_err_a;
    logic [7:0]      cnt_a;
    logic [5:0][5:0] adj_a;
    logic            edge_ready_b, done_b, idx_err_b;
    logic [7:0]      cnt_b;
    logic [5:0][5:0] adj_b;

    coo_to_adj #(.num_of_nodes(6), .idx_w(3), .symmetric(1'b1), .self_loops(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .edge_valid(edge_valid), .edge_ready(edge_ready_a),
        .edge_row(edge_row), .edge_col(edge_col), .edge_last(edge_last), .adj_mat(adj_a),
        .coo_adj_done(done_a), .edge_count(cnt_a), .idx_err(idx_err_a)
    );

    coo_to_adj #(.num_of_nodes(6), .idx_w(3), .symmetric(1'b0), .self_loops(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .edge_valid(edge_valid), .edge_ready(edge_ready_b),
        .edge_row(edge_row), .edge_col(edge_col), .edge_last(edge_last), .adj_mat(adj_b),
        .coo_adj_done(done_b), .edge_count(cnt_b), .idx_err(idx_err_b)
    );

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] c;
    } beat_t;

    beat_t beats[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void add(input int r, input int c);
        beat_t b;
        b.r = 3'(r);
        b.c = 3'(c);
        beats.push_back(b);
    endfunction

    // Reference: matrix as the set of in-range edges, mirrored if undirected, plus I if requested.
    function automatic logic [5:0][5:0] model_mat(input bit sym, input bit sl);
        logic [5:0][5:0] m;
        m = '0;
        foreach (beats[i]) begin
            if (beats[i].r < 3'd6 && beats[i].c < 3'd6) begin
                m[beats[i].r][beats[i].c] = 1'b1;
                if (sym) m[beats[i].c][beats[i].r] = 1'b1;
            end
        end
        if (sl) for (int i = 0; i < 6; i++) m[i][i] = 1'b1;
        return m;
    endfunction

    function automatic int model_cnt();
        return (beats.size() > 255) ? 255 : beats.size();
    endfunction

    function automatic bit model_err();
        foreach (beats[i]) if (beats[i].r >= 3'd6 || beats[i].c >= 3'd6) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_results(input string tag);
        chk({tag, "_adj_a"}, 64'(adj_a), 64'(model_mat(1'b1, 1'b1)));
        chk({tag, "_adj_b"}, 64'(adj_b), 64'(model_mat(1'b0, 1'b0)));
        chk({tag, "_cnt_a"}, 64'(cnt_a), 64'(model_cnt()));
        chk({tag, "_cnt_b"}, 64'(cnt_b), 64'(model_cnt()));
        chk({tag, "_err_a"}, 64'(idx_err_a), 64'(model_err()));
        chk({tag, "_err_b"}, 64'(idx_err_b), 64'(model_err()));
        chk({tag, "_done"}, {62'd0, done_a, done_b}, 64'd3);
        chk({tag, "_ready"}, {62'd0, edge_ready_a, edge_ready_b}, 64'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, {21'd0, adj_a, cnt_a, idx_err_a, done_a, edge_ready_a}, 64'd0);
        chk({tag, "_b"}, {21'd0, adj_b, cnt_b, idx_err_b, done_b, edge_ready_b}, 64'd0);
    endtask

    // Runs one build of the current beat list; inputs driven and outputs sampled on negedges.
    task automatic build(input int gmax, input bit poke_start);
        int idx, gap, cyc;
        bit acc, early;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check_zero("clear");
        idx   = 0;
        gap   = 0;
        early = 1'b0;
        while (idx < beats.size() && cyc < 3000) begin
            if (gap > 0) begin
                edge_valid = 1'b0;
                edge_row   = 3'($urandom_range(7, 0));
                edge_col   = 3'($urandom_range(7, 0));
                edge_last  = 1'($urandom_range(1, 0));
                gap--;
            end else begin
                edge_valid = 1'b1;
                edge_row   = beats[idx].r;
                edge_col   = beats[idx].c;
                edge_last  = (idx == beats.size() - 1);
            end
            start = poke_start && (idx == 1);
            acc   = edge_valid && edge_ready_a;
            if (done_a || done_b) early = 1'b1;
            @(negedge clk);
            cyc++;
            if (acc) begin
                idx++;
                gap = (gmax > 0) ? int'($urandom_range(gmax, 1)) : 0;
            end
        end
        edge_valid = 1'b0;
        start      = 1'b0;
        chk("build_beats", 64'(idx), 64'(beats.size()));
        chk("early_done", 64'(early), 64'd0);
        if (gmax == 0) chk("latency", 64'(cyc), 64'(beats.size() + 2));
        check_results("build");
        repeat (3) @(negedge clk);
        check_results("hold");
    endtask

    initial begin
        logic [5:0][5:0] m;
        logic [5:0]      row_exp;
        int              nacc;
        bit              acc;

        rst        = 1'b1;
        start      = 1'b0;
        edge_valid = 1'b0;
        edge_row   = '0;
        edge_col   = '0;
        edge_last  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_zero("idle");
        end

        // Path graph 0-1-2-3-4-5, continuous valid.
        beats.delete();
        for (int i = 0; i < 5; i++) add(i, i + 1);
        build(0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            row_exp = 6'd1 << r;
            if (r > 0) row_exp |= 6'd1 << (r - 1);
            if (r < 5) row_exp |= 6'd1 << (r + 1);
            chk("path_row", 64'(adj_a[r]), 64'(row_exp));
        end

        // Gaps and a duplicate edge.
        beats.delete();
        add(2, 5); add(2, 5); add(5, 0);
        build(3, 1'b0);
        m = '0;
        m[2][5] = 1'b1;
        m[5][0] = 1'b1;
        chk("dup_only_two", 64'(adj_b), 64'(m));

        // Out-of-range beats only.
        beats.delete();
        add(6, 1); add(1, 7);
        build(1, 1'b0);
        m = '0;
        for (int i = 0; i < 6; i++) m[i][i] = 1'b1;
        chk("oor_identity", 64'(adj_a), 64'(m));
        chk("oor_zero_b", 64'(adj_b), 64'd0);

        // Single out-of-range last beat, then a self-edge on an undirected build.
        beats.delete();
        add(7, 7);
        build(0, 1'b0);
        beats.delete();
        add(3, 3); add(1, 4);
        build(0, 1'b0);

        // Restart from DONE with start pulsed again mid-LOAD.
        beats.delete();
        add(0, 2); add(4, 1); add(5, 5); add(3, 0);
        build(2, 1'b1);

        // Reset after three accepted edges.
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        edge_valid = 1'b1;
        edge_row   = 3'd1;
        edge_col   = 3'd3;
        edge_last  = 1'b0;
        nacc = 0;
        for (int i = 0; i < 20 && nacc < 3; i++) begin
            acc = edge_valid && edge_ready_a;
            @(negedge clk);
            if (acc) nacc++;
        end
        chk("midload_cnt", 64'(cnt_a), 64'd3);
        edge_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("rst_mid");
        @(negedge clk);
        check_zero("rst_idle");
        beats.delete();
        add(1, 2); add(2, 0);
        build(0, 1'b0);

        // Randomized builds.
        for (int t = 0; t < 8; t++) begin
            beats.delete();
            for (int i = 0; i < int'($urandom_range(20, 1)); i++)
                add(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)));
            build(int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        // Count saturation.
        beats.delete();
        for (int i = 0; i < 300; i++) add(int'($urandom_range(5, 0)), int'($urandom_range(5, 0)));
        build(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
